// File: rtl/bp_lce_req_arb_pkg.sv
// bp_lce_req_arb_pkg: shared types, constants and message sizing for the LCE request arbiter
package bp_lce_req_arb_pkg;
  typedef enum logic [1:0] {e_bp_default_cfg, e_bp_unicore_tiny_cfg} bp_params_e;
  typedef struct packed {
    int paddr_width;
    int cce_block_width;
    int lce_id_width;
    int cce_id_width;
    int lce_assoc;
  } bp_proc_param_s;
  typedef enum logic [0:0] {e_reset, e_run} bp_lce_req_arb_state_e;
  localparam int bp_lce_req_arb_buf_els_gp = 2;
  // message type, subop and size fields of the BedRock header
  localparam int bp_bedrock_hdr_fixed_gp = 11;
  function automatic bp_proc_param_s bp_proc_param(input bp_params_e cfg);
    return (cfg == e_bp_unicore_tiny_cfg)
      ? bp_proc_param_s'{paddr_width: 32, cce_block_width: 64, lce_id_width: 2, cce_id_width: 1, lce_assoc: 2}
      : bp_proc_param_s'{paddr_width: 40, cce_block_width: 512, lce_id_width: 4, cce_id_width: 6, lce_assoc: 8};
  endfunction
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int lce_req_msg_width(input bp_params_e cfg);
    bp_proc_param_s p;
    p = bp_proc_param(cfg);
    return bp_bedrock_hdr_fixed_gp + p.paddr_width + p.cce_id_width + p.lce_id_width
         + safe_clog2(p.lce_assoc) + p.cce_block_width;
  endfunction
endpackage

// File: rtl/bp_lce_req_arb_rr.sv
// bp_lce_req_arb_rr: combinational round-robin picker searching from last_i+1
module bp_lce_req_arb_rr
  import bp_lce_req_arb_pkg::*;
#(
  parameter int num_src_p = 2,
  localparam int lg_num_src_lp = safe_clog2(num_src_p)
) (
  input  logic [num_src_p-1:0]     v_i,
  input  logic [lg_num_src_lp-1:0] last_i,
  input  logic                     en_i,
  output logic [num_src_p-1:0]     grant_o,
  output logic [lg_num_src_lp-1:0] grant_idx_o
);
  localparam int iw_lp = lg_num_src_lp + 1;
  logic [iw_lp-1:0] idx;
  logic [lg_num_src_lp-1:0] k;
  // scan offsets farthest-first so the nearest valid source after last_i wins
  always_comb begin
    grant_o = '0;
    grant_idx_o = '0;
    idx = '0;
    k = '0;
    for (int j = num_src_p - 1; j >= 0; j--) begin
      idx = {1'b0, last_i} + iw_lp'(j + 1);
      idx = (idx >= iw_lp'(num_src_p)) ? idx - iw_lp'(num_src_p) : idx;
      k = idx[lg_num_src_lp-1:0];
      if (en_i && v_i[k]) begin
        grant_o = '0;
        grant_o[k] = 1'b1;
        grant_idx_o = k;
      end
    end
  end
endmodule

// File: rtl/bp_lce_req_arb.sv
// bp_lce_req_arb: round-robin arbiter with 2-entry buffer onto one LCE request port; BP_LCE_REQ_ARB_STATS_EN adds grant/stall counters
module bp_lce_req_arb
  import bp_lce_req_arb_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int num_src_p = 2,
  localparam int lg_num_src_lp = safe_clog2(num_src_p),
  localparam int msg_width_lp = lce_req_msg_width(bp_params_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [num_src_p*msg_width_lp-1:0] src_req_i,
  input  logic [num_src_p-1:0]            src_v_i,
  output logic [num_src_p-1:0]            src_ready_o,
  input  logic                            hold_i,
  output logic [msg_width_lp-1:0]         lce_req_o,
  output logic [lg_num_src_lp-1:0]        lce_req_src_o,
  output logic                            lce_req_v_o,
  input  logic                            lce_req_ready_i,
  output logic                            idle_o
`ifdef BP_LCE_REQ_ARB_STATS_EN
  , output logic [num_src_p*32-1:0]       grant_count_o
  , output logic [31:0]                   stall_count_o
`endif
);
  bp_lce_req_arb_state_e state_q;
  logic [1:0] count_q, count_d;
  logic wptr_q, rptr_q;
  logic [lg_num_src_lp-1:0] last_q, grant_idx;
  logic [num_src_p-1:0] grant;
  logic en, enq, deq;
  logic [msg_width_lp-1:0] mem_q [bp_lce_req_arb_buf_els_gp];
  logic [lg_num_src_lp-1:0] src_q [bp_lce_req_arb_buf_els_gp];

  // grants only depend on registered state, valids and hold so ready never sees lce_req_ready_i
  assign en = (state_q == e_run) & ~hold_i & (count_q < 2'(bp_lce_req_arb_buf_els_gp));

  bp_lce_req_arb_rr #(.num_src_p(num_src_p)) rr (
    .v_i(src_v_i),
    .last_i(last_q),
    .en_i(en),
    .grant_o(grant),
    .grant_idx_o(grant_idx)
  );

  assign src_ready_o = grant;
  assign enq = |grant;
  assign deq = lce_req_v_o & lce_req_ready_i;
  assign count_d = count_q + 2'(enq) - 2'(deq);
  assign lce_req_v_o = (count_q != 2'd0);
  assign lce_req_o = mem_q[rptr_q];
  assign lce_req_src_o = src_q[rptr_q];
  assign idle_o = (state_q == e_run) & ~lce_req_v_o & ~|src_v_i;

  // control state: FSM, occupancy, pointers and round-robin history
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state_q <= e_reset;
      count_q <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      last_q <= lg_num_src_lp'(num_src_p - 1);
    end else begin
      state_q <= e_run;
      count_q <= count_d;
      wptr_q <= wptr_q ^ enq;
      rptr_q <= rptr_q ^ deq;
      last_q <= enq ? grant_idx : last_q;
    end

  // buffer storage needs no reset; occupancy alone decides validity
  always_ff @(posedge clk_i)
    if (enq) begin
      mem_q[wptr_q] <= src_req_i[int'(grant_idx)*msg_width_lp +: msg_width_lp];
      src_q[wptr_q] <= grant_idx;
    end

`ifdef BP_LCE_REQ_ARB_STATS_EN
  logic [31:0] grant_cnt_q [num_src_p];
  logic [31:0] stall_cnt_q;
  // saturating per-source grant counters and downstream stall counter
  always_ff @(posedge clk_i)
    if (reset_i) begin
      grant_cnt_q <= '{default: '0};
      stall_cnt_q <= '0;
    end else begin
      for (int s = 0; s < num_src_p; s++)
        grant_cnt_q[s] <= grant_cnt_q[s] + 32'(grant[s] && (grant_cnt_q[s] != '1));
      stall_cnt_q <= stall_cnt_q + 32'(lce_req_v_o && !lce_req_ready_i && (stall_cnt_q != '1));
    end
  for (genvar g = 0; g < num_src_p; g++) begin : gc
    assign grant_count_o[g*32 +: 32] = grant_cnt_q[g];
  end
  assign stall_count_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // grant must be one-hot-or-zero and a full buffer must never accept
  always_ff @(posedge clk_i)
    if (!reset_i) begin
      assert ($onehot0(src_ready_o));
      assert (!(enq && (count_q == 2'd2)));
    end
`endif
endmodule
